// File: rtl/pool_win_collect_pkg.sv
// Shared constants and FSM encoding for the 2x2 max-pool stage.
package pool_pkg;

    localparam int POOL_NWIN  = 9;
    localparam int POOL_DW    = 8;
    localparam int POOL_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } pool_state_t;

endpackage

// File: rtl/pool_win_collect_if.sv
// Pooled-map output handshake: complete vector qualified by out_valid.
interface pool_win_collect_if #(
    parameter int NWIN = pool_pkg::POOL_NWIN,
    parameter int DW   = pool_pkg::POOL_DW
);
    logic [NWIN*DW-1:0] pool_lin;
    logic               out_valid;
    logic               out_ready;

    modport master (output pool_lin, output out_valid, input  out_ready);
    modport slave  (input  pool_lin, input  out_valid, output out_ready);
endinterface

// File: rtl/pool_max4.sv
// Combinational maximum of four values; signed or unsigned compare.
module pool_max4 #(
    parameter int DW     = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] m
);

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] x, input logic [DW-1:0] y);
        if (SIGNED)
            return ($signed(x) > $signed(y)) ? x : y;
        else
            return (x > y) ? x : y;
    endfunction

    assign m = max2(max2(a, b), max2(c, d));

endmodule

// File: rtl/pool_win_collect.sv
// Steps the window index through one pooled map, reduces each 2x2 window
// to its maximum and hands the packed result downstream.
module pool_win_collect
    import pool_pkg::*;
#(
    parameter int NWIN   = POOL_NWIN,
    parameter int DW     = POOL_DW,
    parameter bit SIGNED = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [POOL_CNT_W-1:0] cnt,
    input  logic [DW-1:0]         conv0,
    input  logic [DW-1:0]         conv1,
    input  logic [DW-1:0]         conv2,
    input  logic [DW-1:0]         conv3,
    pool_win_collect_if.master    out_if,
    output logic                  busy
);

    localparam int CNT_W = POOL_CNT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWIN - 1);

    pool_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_en;
    logic [DW-1:0]      win_max;
    logic [NWIN*DW-1:0] pool_q;

    pool_max4 #(.DW(DW), .SIGNED(SIGNED)) u_max4 (
        .a (conv0),
        .b (conv1),
        .c (conv2),
        .d (conv3),
        .m (win_max)
    );

    // State and window index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, next index and slot write enable.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        wr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                wr_en = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_if.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write the current window maximum into its slot; other slots hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pool_q <= '0;
        end else if (wr_en) begin
            for (int unsigned k = 0; k < NWIN; k++) begin
                if (cnt_q == CNT_W'(k)) pool_q[k*DW +: DW] <= win_max;
            end
        end
    end

    assign cnt              = cnt_q;
    assign out_if.pool_lin  = pool_q;
    assign out_if.out_valid = (state_q == ST_DONE);
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pool_win_collect.sv
// Bench for pool_win_collect: an unsigned and a signed instance share a
// 6x6 map model that answers each instance's window index.
module tb_pool_win_collect;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        out_ready;
    logic [3:0]  cnt_u, cnt_s;
    logic [31:0] pix_u, pix_s;
    logic        busy_u, busy_s;
    int          base_u, base_s;
    logic [7:0]  map [36];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] c0, c1, c2, c3;
        logic [7:0] exp_u, exp_s;
    } vec_t;

    vec_t tab [18];

    pool_win_collect_if #(.NWIN(9), .DW(8)) if_u ();
    pool_win_collect_if #(.NWIN(9), .DW(8)) if_s ();

    assign if_u.out_ready = out_ready;
    assign if_s.out_ready = out_ready;

    pool_win_collect #(.NWIN(9), .DW(8), .SIGNED(1'b0)) u_dut_u (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cnt    (cnt_u),
        .conv0  (pix_u[31:24]),
        .conv1  (pix_u[23:16]),
        .conv2  (pix_u[15:8]),
        .conv3  (pix_u[7:0]),
        .out_if (if_u),
        .busy   (busy_u)
    );

    pool_win_collect #(.NWIN(9), .DW(8), .SIGNED(1'b1)) u_dut_s (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cnt    (cnt_s),
        .conv0  (pix_s[31:24]),
        .conv1  (pix_s[23:16]),
        .conv2  (pix_s[15:8]),
        .conv3  (pix_s[7:0]),
        .out_if (if_s),
        .busy   (busy_s)
    );

    always #5 clk = ~clk;

    // Window mux model for the unsigned instance.
    always_comb begin
        base_u = 0;
        pix_u  = '0;
        if (cnt_u < 4'd9) begin
            base_u = 12 * (int'(cnt_u) / 3) + 2 * (int'(cnt_u) % 3);
            pix_u  = {map[base_u], map[base_u+1], map[base_u+6], map[base_u+7]};
        end
    end

    // Window mux model for the signed instance.
    always_comb begin
        base_s = 0;
        pix_s  = '0;
        if (cnt_s < 4'd9) begin
            base_s = 12 * (int'(cnt_s) / 3) + 2 * (int'(cnt_s) % 3);
            pix_s  = {map[base_s], map[base_s+1], map[base_s+6], map[base_s+7]};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] model_max(input int k, input bit sgn);
        int b;
        logic [7:0] v [4];
        logic [7:0] m;
        b = 12 * (k / 3) + 2 * (k % 3);
        v[0] = map[b]; v[1] = map[b+1]; v[2] = map[b+6]; v[3] = map[b+7];
        m = v[0];
        for (int i = 1; i < 4; i++) begin
            if (sgn) begin
                if ($signed(v[i]) > $signed(m)) m = v[i];
            end else begin
                if (v[i] > m) m = v[i];
            end
        end
        return m;
    endfunction

    function automatic logic [71:0] model_vec(input bit sgn);
        logic [71:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[k*8 +: 8] = model_max(k, sgn);
        return r;
    endfunction

    task automatic load_tab(input int first);
        for (int k = 0; k < 9; k++) begin
            int b;
            b = 12 * (k / 3) + 2 * (k % 3);
            map[b]   = tab[first+k].c0;
            map[b+1] = tab[first+k].c1;
            map[b+6] = tab[first+k].c2;
            map[b+7] = tab[first+k].c3;
        end
    endtask

    // Start pulse plus ten edges; ends with out_valid expected high.
    task automatic run_pass(input string nm);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk({nm, "_valid_u"}, 72'(if_u.out_valid), 72'd1);
        chk({nm, "_valid_s"}, 72'(if_s.out_valid), 72'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0]  ramp_exp [9];
        logic [71:0] exp_u, exp_s;
        int vcount;

        ramp_exp = '{8'd7, 8'd9, 8'd11, 8'd19, 8'd21, 8'd23, 8'd31, 8'd33, 8'd35};

        // Pass A: all -5 except window 4 bottom-left -1.
        for (int k = 0; k < 9; k++) tab[k] = '{8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB};
        tab[4] = '{8'hFB, 8'hFB, 8'hFF, 8'hFB, 8'hFF, 8'hFF};
        // Pass B: mixed signs, winner in varying positions.
        tab[9]  = '{8'h80, 8'h7F, 8'h00, 8'h01, 8'h80, 8'h7F};
        tab[10] = '{8'h01, 8'hFE, 8'h7F, 8'h00, 8'hFE, 8'h7F};
        tab[11] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tab[12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tab[13] = '{8'h10, 8'h20, 8'h30, 8'h05, 8'h30, 8'h30};
        tab[14] = '{8'h05, 8'h30, 8'h20, 8'h10, 8'h30, 8'h30};
        tab[15] = '{8'h81, 8'h82, 8'h83, 8'h80, 8'h83, 8'h83};
        tab[16] = '{8'h7F, 8'h80, 8'hFF, 8'h01, 8'hFF, 8'h7F};
        tab[17] = '{8'h00, 8'hC0, 8'h40, 8'h00, 8'hC0, 8'h40};

        for (int i = 0; i < 36; i++) map[i] = 8'(i);
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_cnt",   72'(cnt_u), 72'd0);
        chk("rst_pool",  if_u.out_valid ? 72'hx : if_u.pool_lin, 72'd0);
        chk("rst_valid", 72'(if_s.out_valid), 72'd0);
        chk("rst_busy",  72'({busy_u, busy_s}), 72'd0);
        #2 rst_n = 1'b1;
        tick();

        // Ramp: latency, cnt sequence and slot values.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("ramp_cnt%0d", i), 72'(cnt_u), 72'(i));
            chk($sformatf("ramp_novalid%0d", i), 72'(if_u.out_valid), 72'd0);
            chk($sformatf("ramp_busy%0d", i), 72'(busy_u), 72'd1);
            tick();
        end
        chk("ramp_valid", 72'(if_u.out_valid), 72'd1);
        chk("ramp_cnt_end", 72'(cnt_u), 72'd0);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("ramp_u_slot%0d", k), 72'(if_u.pool_lin[k*8 +: 8]), 72'(ramp_exp[k]));
            chk($sformatf("ramp_s_slot%0d", k), 72'(if_s.pool_lin[k*8 +: 8]), 72'(ramp_exp[k]));
        end
        handshake();

        // Table passes A and B, both compare modes.
        for (int p = 0; p < 2; p++) begin
            load_tab(p * 9);
            run_pass($sformatf("tab%0d", p));
            for (int k = 0; k < 9; k++) begin
                chk($sformatf("tab%0d_u_slot%0d", p, k), 72'(if_u.pool_lin[k*8 +: 8]), 72'(tab[p*9+k].exp_u));
                chk($sformatf("tab%0d_s_slot%0d", p, k), 72'(if_s.pool_lin[k*8 +: 8]), 72'(tab[p*9+k].exp_s));
            end
            if (p == 0) handshake();
        end

        // Backpressure on pass B result; start in DONE must be dropped.
        exp_u = '0; exp_s = '0;
        for (int k = 0; k < 9; k++) begin
            exp_u[k*8 +: 8] = tab[9+k].exp_u;
            exp_s[k*8 +: 8] = tab[9+k].exp_s;
        end
        for (int j = 0; j < 20; j++) begin
            start = (j == 10);
            if (j == 5) for (int i = 0; i < 36; i++) map[i] = 8'hAA;
            tick();
            start = 1'b0;
            chk($sformatf("bp_valid%0d", j), 72'(if_u.out_valid), 72'd1);
            chk($sformatf("bp_pool_u%0d", j), if_u.pool_lin, exp_u);
            chk($sformatf("bp_pool_s%0d", j), if_s.pool_lin, exp_s);
        end
        handshake();
        chk("bp_release_valid", 72'(if_u.out_valid), 72'd0);
        chk("bp_release_busy", 72'({busy_u, busy_s}), 72'd0);
        repeat (3) tick();
        chk("bp_no_queued_start", 72'({busy_u, busy_s}), 72'd0);

        // Back-to-back with out_ready held high.
        for (int i = 0; i < 36; i++) map[i] = 8'(i);
        out_ready = 1'b1;
        run_pass("b2b_first");
        chk("b2b_first_u", if_u.pool_lin, model_vec(1'b0));
        for (int i = 0; i < 36; i++) map[i] = 8'(135 - i);
        tick();
        chk("b2b_idle", 72'(busy_u), 72'd0);
        run_pass("b2b_second");
        chk("b2b_second_u", if_u.pool_lin, model_vec(1'b0));
        chk("b2b_second_s", if_s.pool_lin, model_vec(1'b1));
        chk("b2b_s_slot1", 72'(if_s.pool_lin[15:8]), 72'h7F);
        tick();
        out_ready = 1'b0;

        // Reset in the middle of a pass.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("mid_cnt_before", 72'(cnt_u), 72'd4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", 72'(cnt_u), 72'd0);
        chk("mid_rst_pool_u", if_u.pool_lin, 72'd0);
        chk("mid_rst_pool_s", if_s.pool_lin, 72'd0);
        chk("mid_rst_valid_busy", 72'({if_u.out_valid, busy_u}), 72'd0);
        #2 rst_n = 1'b1;
        tick();
        load_tab(0);
        run_pass("after_rst");
        for (int k = 0; k < 9; k++)
            chk($sformatf("after_rst_s_slot%0d", k), 72'(if_s.pool_lin[k*8 +: 8]), 72'(tab[k].exp_s));
        handshake();

        // Start pulse during RUN is ignored.
        for (int i = 0; i < 36; i++) map[i] = 8'(i);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("run_start_cnt%0d", i), 72'(cnt_u), 72'(i));
            start = (i == 3);
            tick();
            start = 1'b0;
        end
        chk("run_start_pool", if_u.pool_lin, model_vec(1'b0));
        vcount = 0;
        for (int j = 0; j < 15; j++) begin
            if (if_u.out_valid) vcount++;
            tick();
        end
        chk("run_start_one_valid", 72'(vcount), 72'd1);
        chk("run_start_idle", 72'({busy_u, busy_s}), 72'd0);
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pool_win_collect.md
Name: pool_win_collect

Overview:
- Sequencing and write-back end of the 2x2 max-pool stage.
- Drives the 4-bit window index `cnt` into the window mux, which returns four 8-bit conv values.
- Reduces each window to its maximum and writes the result into a packed 3x3x8 pooled output vector.
- Presents the complete vector to the next stage with a valid/ready handshake. Sits between the conv buffer/window mux and the FC/next-layer input.

Parameters:
- NWIN, 9, windows per feature map (3x3 pooled output); `cnt` runs 0..NWIN-1.
- DW, 8, data width of each conv value and pooled value.
- SIGNED, 0, 0 = unsigned compare (post-ReLU data); 1 = two's-complement compare.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts one 9-window pass; honoured only in IDLE.
- cnt  out  4  window index to the mux; 0 = row0/col0, row-major, 8 = row2/col2.
- conv0  in  DW  window top-left, combinational response to `cnt`.
- conv1  in  DW  window top-right.
- conv2  in  DW  window bottom-left.
- conv3  in  DW  window bottom-right.
- pool_lin  out  NWIN*DW  pooled map; window k at `[k*DW +: DW]`.
- out_valid  out  1  `pool_lin` complete and stable.
- out_ready  in  1  downstream accepts `pool_lin`.
- busy  out  1  high in RUN or DONE.

Behaviour:
- **Reset** (rst_n low, async): state=IDLE, cnt=0, pool_lin=0, out_valid=0, busy=0.
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - start=1 -> RUN; cnt=0 on the next edge.
  - cnt is held at 0; pool_lin retains the previous result.
- **RUN:**
  - Each cycle, max(conv0..conv3) is computed combinationally from the current `cnt`.
  - On the clock edge the max is written to `pool_lin[cnt*DW +: DW]`.
  - cnt<NWIN-1: cnt increments.
  - cnt==NWIN-1: write slot 8, cnt returns to 0, state -> DONE, out_valid=1.
- **DONE:**
  - out_valid=1; pool_lin is frozen.
  - out_valid & out_ready -> IDLE and out_valid=0 on that edge.
  - out_ready low: hold indefinitely.
- **Latency:** start sampled at edge E0; slots 0..8 written at E1..E9; out_valid high after E9; minimum 10 cycles start-to-valid.
- **Throughput:** with out_ready tied high, a new start is accepted from the cycle after the handshake. Maximum one map per 11 cycles.
- **start** in RUN/DONE is ignored; it is neither queued nor an error.
- **Max compare:**
  - SIGNED=0: unsigned.
  - SIGNED=1: signed.
  - Ties: any equal value; the result is identical.
  - No saturation or width change; output is DW bits.
- **Slot clearing:** slots not yet written in the current pass keep the previous pass's values. Only out_valid qualifies pool_lin.
- **Reset mid-RUN or mid-DONE:** immediate return to reset values; the partial result is discarded.
- **cnt** never exceeds NWIN-1, so the mux default branch is never selected.

Decomposition:
- Shared package (pool_pkg) holds:
  - POOL_NWIN=9, POOL_DW=8, POOL_CNT_W=4.
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One natural sub-module: pool_max4, combinational 4-input max with a SIGNED parameter. It is reusable by other pool instances.

Test Plan:
- **Ramp:** bench mux model loads a 6x6 map with value(r,c)=r*6+c, unsigned; pulse start -> out_valid after 10 cycles; slots 0..8 = 7,9,11,19,21,23,31,33,35; cnt sequence 0..8 observed.
- **Signed:** SIGNED=1, all conv=-5 (0xFB) except window 4 conv2=-1 (0xFF) -> slot 4=0xFF, others 0xFB. SIGNED=0 with the same data -> every slot 0xFB except slot 4=0xFF; also check conv0=0x80 vs 0x7F picks 0x7F signed, 0x80 unsigned.
- **Backpressure:** out_ready=0 for 20 cycles after valid -> pool_lin and out_valid stable; a start pulse in DONE is ignored. out_ready=1 -> IDLE next cycle, busy=0.
- **Back-to-back:** out_ready tied 1, start re-pulsed on the cycle after the handshake -> second map valid 10 cycles later with new data; no slot from the first map leaks.
- **Reset mid-run:** drop rst_n at cnt=4 -> outputs zero asynchronously; release, start -> full correct 9-slot result.
- **Start in RUN:** pulse start at cnt=3 -> cnt continues 4..8 unperturbed; exactly one out_valid.
